// File: rtl/glip_cypressfx3_slavefifo_model_if.sv
// GPIF slave-FIFO bus plus host-side endpoint streams of the FX3 model.
// The slave modport is the FX3 model; the master modport is the FPGA/host side.
interface glip_cypressfx3_slavefifo_model_if #(
  parameter int WIDTH = 16
);
  logic             fx3_slcs_n;
  logic             fx3_slrd_n;
  logic             fx3_slwr_n;
  logic             fx3_sloe_n;
  logic             fx3_pktend_n;
  logic [1:0]       fx3_a;
  logic [WIDTH-1:0] fx3_dq_i;
  logic [WIDTH-1:0] fx3_dq_o;
  logic             fx3_dq_oe;
  logic             fx3_flaga;
  logic             fx3_flagb;
  logic             fx3_flagc;
  logic             host_in_valid;
  logic             host_in_ready;
  logic [WIDTH-1:0] host_in_data;
  logic             host_out_valid;
  logic             host_out_ready;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_last;
  logic [2:0]       err;

  modport slave (
    input  fx3_slcs_n, fx3_slrd_n, fx3_slwr_n, fx3_sloe_n, fx3_pktend_n, fx3_a, fx3_dq_i,
    output fx3_dq_o, fx3_dq_oe, fx3_flaga, fx3_flagb, fx3_flagc,
    input  host_in_valid, host_in_data, host_out_ready,
    output host_in_ready, host_out_valid, host_out_data, host_out_last, err
  );

  modport master (
    output fx3_slcs_n, fx3_slrd_n, fx3_slwr_n, fx3_sloe_n, fx3_pktend_n, fx3_a, fx3_dq_i,
    input  fx3_dq_o, fx3_dq_oe, fx3_flaga, fx3_flagb, fx3_flagc,
    output host_in_valid, host_in_data, host_out_ready,
    input  host_in_ready, host_out_valid, host_out_data, host_out_last, err
  );
endinterface

// File: rtl/glip_cypressfx3_slavefifo_model.sv
// Cycle-level model of the Cypress FX3 slave-FIFO endpoint pair (EP-OUT read, EP-IN write)
// with host-side ready/valid streams, registered flags and sticky error reporting.
module glip_cypressfx3_slavefifo_model #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int AF_MARGIN = 4,
  parameter int READ_LAT  = 2,
  parameter int PKT_WORDS = 256
) (
  input logic clk,
  input logic rst,
  glip_cypressfx3_slavefifo_model_if.slave fx3
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [WIDTH:0]   in_mem  [DEPTH];
  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [AW-1:0]    in_wp, in_rp, out_wp, out_rp;
  logic [CW-1:0]    in_cnt, out_cnt, in_cnt_nx, out_cnt_nx;
  logic [PW-1:0]    pkt_cnt;
  logic [0:0]       pkt_state;
  logic [WIDTH-1:0] dq_p [READ_LAT];
  logic             flaga_q, flagb_q, flagc_q;
  logic [2:0]       err_q;

  logic cs, rd_req, wr_req, pkt_req, viol, rd, wr;
  logic in_full, out_empty, push_in, pop_in, push_out, pop_out;
  logic word_last, tag_prev;

  always_comb begin
    cs        = ~fx3.fx3_slcs_n;
    rd_req    = cs & ~fx3.fx3_slrd_n;
    wr_req    = cs & ~fx3.fx3_slwr_n;
    pkt_req   = cs & ~fx3.fx3_pktend_n;
    viol      = (rd_req & wr_req) | (wr_req & (fx3.fx3_a != 2'b00)) | (rd_req & (fx3.fx3_a != 2'b11));
    rd        = rd_req & ~viol;
    wr        = wr_req & ~viol;
    in_full   = (in_cnt == CW'(DEPTH));
    out_empty = (out_cnt == '0);
    push_in   = wr & ~in_full;
    pop_in    = (in_cnt != '0) & fx3.host_out_ready;
    push_out  = fx3.host_in_valid & (out_cnt != CW'(DEPTH));
    pop_out   = rd & ~out_empty;
    word_last = pkt_req | (pkt_cnt == PW'(PKT_WORDS - 1));
    // A bare pktend closes the open packet by re-tagging the word already stored.
    tag_prev  = pkt_req & ~viol & ~push_in & (pkt_state == ACTIVE);
    in_cnt_nx  = in_cnt + CW'(push_in) - CW'(pop_in);
    out_cnt_nx = out_cnt + CW'(push_out) - CW'(pop_out);
  end

  always_ff @(posedge clk) begin
    if (push_in)
      in_mem[in_wp] <= {word_last, fx3.fx3_dq_i};
    else if (tag_prev)
      in_mem[in_wp - 1'b1][WIDTH] <= 1'b1;
    if (push_out)
      out_mem[out_wp] <= fx3.host_in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wp     <= '0;
      in_rp     <= '0;
      out_wp    <= '0;
      out_rp    <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      pkt_cnt   <= '0;
      pkt_state <= IDLE;
      flaga_q   <= 1'b1;
      flagb_q   <= 1'b1;
      flagc_q   <= 1'b0;
      err_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) dq_p[i] <= '0;
    end else begin
      if (push_in)  in_wp  <= in_wp + 1'b1;
      if (pop_in)   in_rp  <= in_rp + 1'b1;
      if (push_out) out_wp <= out_wp + 1'b1;
      if (pop_out)  out_rp <= out_rp + 1'b1;
      in_cnt  <= in_cnt_nx;
      out_cnt <= out_cnt_nx;
      flaga_q <= (in_cnt_nx < CW'(DEPTH));
      flagb_q <= ((CW'(DEPTH) - in_cnt_nx) > CW'(AF_MARGIN));
      flagc_q <= (out_cnt_nx != '0);
      err_q   <= err_q | {viol, rd & out_empty, wr & in_full};

      if (push_in) begin
        if (word_last) begin
          pkt_cnt   <= '0;
          pkt_state <= IDLE;
        end else begin
          pkt_cnt   <= pkt_cnt + 1'b1;
          pkt_state <= ACTIVE;
        end
      end else if (tag_prev) begin
        pkt_cnt   <= '0;
        pkt_state <= IDLE;
      end

      // p0: popped word (or zero on empty/idle) enters the read-latency pipeline
      dq_p[0] <= pop_out ? out_mem[out_rp] : '0;
      // p1..pN: pure delay up to the dq output register
      for (int i = 1; i < READ_LAT; i++) dq_p[i] <= dq_p[i-1];
    end
  end

  assign fx3.fx3_dq_o       = dq_p[READ_LAT-1];
  assign fx3.fx3_dq_oe      = ~fx3.fx3_sloe_n & cs & (fx3.fx3_a == 2'b11);
  assign fx3.fx3_flaga      = flaga_q;
  assign fx3.fx3_flagb      = flagb_q;
  assign fx3.fx3_flagc      = flagc_q;
  assign fx3.host_in_ready  = (out_cnt != CW'(DEPTH));
  assign fx3.host_out_valid = (in_cnt != '0);
  assign fx3.host_out_data  = in_mem[in_rp][WIDTH-1:0];
  assign fx3.host_out_last  = (in_cnt != '0) & in_mem[in_rp][WIDTH];
  assign fx3.err            = err_q;
endmodule

// File: tb/tb_glip_cypressfx3_slavefifo_model.sv
// Directed bench for the FX3 slave-FIFO model: read streaming, packetisation, flags, errors, reset.
module tb_glip_cypressfx3_slavefifo_model;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  glip_cypressfx3_slavefifo_model_if #(.WIDTH(16)) bus ();

  glip_cypressfx3_slavefifo_model #(
    .WIDTH(16), .DEPTH(64), .AF_MARGIN(4), .READ_LAT(2), .PKT_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fx3(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.fx3_slcs_n     = 1'b1;
    bus.fx3_slrd_n     = 1'b1;
    bus.fx3_slwr_n     = 1'b1;
    bus.fx3_sloe_n     = 1'b1;
    bus.fx3_pktend_n   = 1'b1;
    bus.fx3_a          = 2'b00;
    bus.fx3_dq_i       = 16'h0;
    bus.host_in_valid  = 1'b0;
    bus.host_in_data   = 16'h0;
    bus.host_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic host_push(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_data  = base + 16'(i);
      tick();
    end
    bus.host_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    got = {bus.fx3_dq_oe, bus.fx3_flaga, bus.fx3_flagb, bus.fx3_flagc, bus.host_out_valid,
           bus.host_out_last, bus.host_in_ready, bus.err};
    checks++;
    if (got !== 10'b0_1_1_0_0_0_1_000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required %b", got, 10'b0_1_1_0_0_0_1_000);
    end
    checks++;
    if (bus.fx3_dq_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_dq_o got %h required 0000", bus.fx3_dq_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_stream();
    logic [15:0] exp;
    host_push(16'h0001, 16);
    checks++;
    if (bus.fx3_flagc !== 1'b1) begin
      errors++;
      $display("FAIL stream_flagc_filled got %b required 1", bus.fx3_flagc);
    end
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b11;
    bus.fx3_sloe_n = 1'b0;
    bus.fx3_slrd_n = 1'b0;
    #1;
    checks++;
    if (bus.fx3_dq_oe !== 1'b1) begin
      errors++;
      $display("FAIL stream_dq_oe_on got %b required 1", bus.fx3_dq_oe);
    end
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (cyc == 16) bus.fx3_slrd_n = 1'b1;
      exp = (cyc >= 2 && cyc <= 17) ? 16'(cyc - 1) : 16'h0;
      checks++;
      if (bus.fx3_dq_o !== exp) begin
        errors++;
        $display("FAIL stream_dq_o cycle %0d got %h required %h", cyc, bus.fx3_dq_o, exp);
      end
      if (cyc == 15 || cyc == 16) begin
        checks++;
        if (bus.fx3_flagc !== (cyc == 15)) begin
          errors++;
          $display("FAIL stream_flagc cycle %0d got %b required %b", cyc, bus.fx3_flagc, cyc == 15);
        end
      end
    end
    bus.fx3_sloe_n = 1'b1;
    #1;
    checks++;
    if (bus.fx3_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL stream_dq_oe_off got %b required 0", bus.fx3_dq_oe);
    end
    checks++;
    if (bus.err !== 3'b000) begin
      errors++;
      $display("FAIL stream_err got %b required 000", bus.err);
    end
    idle_bus();
  endtask

  task automatic test_pktend();
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b00;
    for (int i = 0; i < 3; i++) begin
      bus.fx3_slwr_n = 1'b0;
      bus.fx3_dq_i   = 16'hA0A0 + 16'(i);
      tick();
    end
    bus.fx3_slwr_n   = 1'b1;
    bus.fx3_pktend_n = 1'b0;
    tick();
    idle_bus();
    bus.host_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.host_out_valid !== 1'b1 || bus.host_out_data !== 16'hA0A0 + 16'(i) ||
          bus.host_out_last !== (i == 2)) begin
        errors++;
        $display("FAIL pktend_word %0d got v=%b d=%h l=%b required v=1 d=%h l=%b", i,
                 bus.host_out_valid, bus.host_out_data, bus.host_out_last, 16'hA0A0 + 16'(i), i == 2);
      end
      tick();
    end
    checks++;
    if (bus.host_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pktend_drained got valid %b required 0", bus.host_out_valid);
    end
    idle_bus();
  endtask

  task automatic test_packet_256();
    int seen = 0;
    bus.host_out_ready = 1'b1;
    bus.fx3_slcs_n     = 1'b0;
    bus.fx3_a          = 2'b00;
    for (int i = 0; i < 261; i++) begin
      if (i < 258) begin
        bus.fx3_slwr_n   = 1'b0;
        bus.fx3_dq_i     = 16'h1000 + 16'(i);
        bus.fx3_pktend_n = (i == 257) ? 1'b0 : 1'b1;
      end else begin
        bus.fx3_slwr_n   = 1'b1;
        bus.fx3_pktend_n = 1'b1;
      end
      tick();
      if (bus.host_out_valid === 1'b1) begin
        checks++;
        if (bus.host_out_data !== 16'h1000 + 16'(seen) ||
            bus.host_out_last !== (seen == 255 || seen == 257)) begin
          errors++;
          $display("FAIL pkt256_word %0d got d=%h l=%b required d=%h l=%b", seen, bus.host_out_data,
                   bus.host_out_last, 16'h1000 + 16'(seen), seen == 255 || seen == 257);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 258) begin
      errors++;
      $display("FAIL pkt256_count got %0d required 258", seen);
    end
    idle_bus();
  endtask

  task automatic test_fill();
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b00;
    for (int k = 1; k <= 65; k++) begin
      bus.fx3_slwr_n = 1'b0;
      bus.fx3_dq_i   = 16'h2000 + 16'(k);
      tick();
      if (k == 59 || k == 60 || k == 63 || k == 64 || k == 65) begin
        checks++;
        if (bus.fx3_flagb !== (k < 60) || bus.fx3_flaga !== (k < 64) || bus.err[0] !== (k == 65)) begin
          errors++;
          $display("FAIL fill_flags count %0d got a=%b b=%b e0=%b required a=%b b=%b e0=%b", k,
                   bus.fx3_flaga, bus.fx3_flagb, bus.err[0], k < 64, k < 60, k == 65);
        end
      end
    end
    idle_bus();
    bus.host_out_ready = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      checks++;
      if (bus.host_out_valid !== 1'b1 || bus.host_out_data !== 16'h2000 + 16'(k) ||
          bus.host_out_last !== 1'b0) begin
        errors++;
        $display("FAIL fill_drain %0d got v=%b d=%h l=%b required v=1 d=%h l=0", k,
                 bus.host_out_valid, bus.host_out_data, bus.host_out_last, 16'h2000 + 16'(k));
      end
      tick();
    end
    checks++;
    if (bus.host_out_valid !== 1'b0 || bus.fx3_flaga !== 1'b1 || bus.fx3_flagb !== 1'b1) begin
      errors++;
      $display("FAIL fill_empty got v=%b a=%b b=%b required v=0 a=1 b=1", bus.host_out_valid,
               bus.fx3_flaga, bus.fx3_flagb);
    end
    idle_bus();
  endtask

  task automatic test_protocol();
    do_reset();
    host_push(16'h5555, 1);
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b11;
    bus.fx3_slrd_n = 1'b0;
    bus.fx3_slwr_n = 1'b0;
    tick();
    bus.fx3_slrd_n = 1'b1;
    bus.fx3_slwr_n = 1'b1;
    checks++;
    if (bus.err !== 3'b100 || bus.fx3_flagc !== 1'b1 || bus.host_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_rdwr got err=%b c=%b v=%b required err=100 c=1 v=0", bus.err,
               bus.fx3_flagc, bus.host_out_valid);
    end
    bus.fx3_slcs_n = 1'b1;
    bus.fx3_a      = 2'b00;
    bus.fx3_slwr_n = 1'b0;
    tick();
    bus.fx3_slwr_n = 1'b1;
    checks++;
    if (bus.host_out_valid !== 1'b0 || bus.err !== 3'b100) begin
      errors++;
      $display("FAIL proto_cs_ignored got v=%b err=%b required v=0 err=100", bus.host_out_valid, bus.err);
    end
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b11;
    bus.fx3_slrd_n = 1'b0;
    tick();
    tick();
    bus.fx3_slrd_n = 1'b1;
    checks++;
    if (bus.fx3_dq_o !== 16'h5555 || bus.err !== 3'b110 || bus.fx3_flagc !== 1'b0) begin
      errors++;
      $display("FAIL proto_underflow got dq=%h err=%b c=%b required dq=5555 err=110 c=0",
               bus.fx3_dq_o, bus.err, bus.fx3_flagc);
    end
    tick();
    checks++;
    if (bus.fx3_dq_o !== 16'h0) begin
      errors++;
      $display("FAIL proto_empty_data got %h required 0000", bus.fx3_dq_o);
    end
    idle_bus();
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    do_reset();
    host_push(16'h0030, 16);
    bus.fx3_slcs_n = 1'b0;
    bus.fx3_a      = 2'b11;
    bus.fx3_slrd_n = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.fx3_dq_o !== 16'h0032) begin
      errors++;
      $display("FAIL rstmid_before got %h required 0032", bus.fx3_dq_o);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.fx3_flaga, bus.fx3_flagb, bus.fx3_flagc, bus.host_out_valid, bus.host_out_last,
           bus.host_in_ready, bus.err};
    checks++;
    if (got !== 9'b1_1_0_0_0_1_000 || bus.fx3_dq_o !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async got ctrl=%b dq=%h required ctrl=110001000 dq=0000", got, bus.fx3_dq_o);
    end
    idle_bus();
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.fx3_flagc !== 1'b0 || bus.fx3_dq_o !== 16'h0 || bus.host_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got c=%b dq=%h rdy=%b required c=0 dq=0000 rdy=1", bus.fx3_flagc,
               bus.fx3_dq_o, bus.host_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read_stream();
    test_pktend();
    test_packet_256();
    test_fill();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
